// File: rtl/drive_cmd_gen.sv
// drive_cmd_gen: debounced button drive FSM producing serial command bytes
module drive_cmd_gen #(
  parameter int DB_CYCLES    = 2000000,
  parameter int BRAKE_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       sw_power,
  input  logic [3:0] sensor,
  output logic [7:0] cmd_byte,
  output logic       cmd_changed,
  output logic [1:0] state
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int BW = BRAKE_CYCLES > 1 ? $clog2(BRAKE_CYCLES) : 1;
  typedef enum logic [1:0] {OFF, IDLE, DRIVE, BRAKE} state_t;
  state_t cur, nxt;
  logic [4:0] raw, sync1, sync2, clean;
  logic [3:0] req, motion;
  logic [1:0] last_dir;
  logic [BW-1:0] brake_cnt;
  logic pwr, reverse, brake_done;
  logic [7:0] cmd_next;
  assign raw = {sw_power, btn_right, btn_left, btn_back, btn_fwd};
  // two-flop synchronizer for all raw inputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) {sync1, sync2} <= '0;
    else {sync1, sync2} <= {raw, sync1};
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic lvl;
    assign clean[i] = lvl;
    // clean level flips only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) cnt <= '0;
      else if (cnt == DW'(DB_CYCLES - 1)) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
  end
  assign pwr = clean[4];
  assign req = {clean[3] & ~clean[2] & ~sensor[2],
                clean[2] & ~clean[3] & ~sensor[1],
                clean[1] & ~clean[0] & ~sensor[3],
                clean[0] & ~clean[1] & ~sensor[0]};
  assign reverse = (req[0] & last_dir[1]) | (req[1] & last_dir[0]);
  assign brake_done = brake_cnt == BW'(BRAKE_CYCLES - 1);
  assign state = cur;
  // state register with brake timer and last longitudinal direction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur       <= OFF;
      brake_cnt <= '0;
      last_dir  <= '0;
    end else begin
      cur       <= nxt;
      brake_cnt <= (cur == BRAKE && nxt == BRAKE) ? brake_cnt + 1'b1 : '0;
      last_dir  <= (nxt == IDLE || nxt == OFF) ? 2'b00 :
                   (nxt == DRIVE && |req[1:0]) ? req[1:0] : last_dir;
    end
  // next state: power loss wins, brake hold ignores new requests until done
  always_comb
    nxt = !pwr         ? OFF :
          cur == OFF   ? IDLE :
          cur == IDLE  ? (|req ? DRIVE : IDLE) :
          cur == DRIVE ? (!(|req) ? IDLE : reverse ? BRAKE : DRIVE) :
          brake_done   ? (|req ? DRIVE : IDLE) : BRAKE;
  // motion only while staying in DRIVE, so a reversal never leaks one cycle of the new direction
  always_comb begin
    motion   = (cur == DRIVE && nxt == DRIVE) ? req : 4'b0000;
    cmd_next = {4'b1000, motion};
  end
  // registered command byte and its change strobe
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cmd_byte    <= 8'h80;
      cmd_changed <= 1'b0;
    end else begin
      cmd_byte    <= cmd_next;
      cmd_changed <= cmd_next != cmd_byte;
    end
endmodule
